// File: rtl/sort_engine.sv
// sort_engine: buffers up to DEPTH words, bubble-sorts them in place with a
// single shared comparator (one compare/swap per clock), then streams them out.

// Strict less-than comparator on N+1-bit operands.
module comparator #(
    parameter int N = 8
) (
    input  logic [N:0] x,
    input  logic [N:0] y,
    output logic       z
);
    assign z = (x < y);
endmodule

module sort_engine #(
    parameter int N     = 8,
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [N:0] in_data,
    output logic       in_ready,
    input  logic       start,
    output logic       busy,
    output logic       sorted,
    output logic       out_valid,
    output logic [N:0] out_data,
    input  logic       out_ready
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    state_t        state, state_n;
    logic [N:0]    mem [DEPTH];
    logic [CW-1:0] count, count_n, count_w;
    logic [IW-1:0] i, i_n, limit, limit_n, rd, rd_n, ip1;
    logic          swapped, swapped_n, sorted_q;
    logic          accept, do_swap, cmp_z;

    assign ip1 = i + IW'(1);

    // The one comparator: z=1 means the upper word is strictly smaller.
    comparator #(.N(N)) u_cmp (
        .x(mem[ip1]),
        .y(mem[i]),
        .z(cmp_z)
    );

    // Outputs are decoded purely from registered state.
    assign in_ready  = (state == LOAD) && (count < FULL);
    assign busy      = (state == SORT);
    assign out_valid = (state == DRAIN);
    assign sorted    = sorted_q;
    assign out_data  = out_valid ? mem[rd] : '0;
    assign accept    = in_valid & in_ready;

    // Next-state and datapath control.
    always_comb begin
        state_n   = state;
        count_n   = count;
        i_n       = i;
        limit_n   = limit;
        rd_n      = rd;
        swapped_n = swapped;
        do_swap   = 1'b0;
        count_w   = count + CW'(accept);
        case (state)
            LOAD: begin
                count_n = count_w;
                // A word handshaken on the same edge as start is part of the batch.
                if (start && (count_w != '0)) begin
                    state_n   = SORT;
                    i_n       = '0;
                    limit_n   = IW'(count_w - CW'(1));
                    swapped_n = 1'b0;
                end
            end
            SORT: begin
                if (limit == '0) begin
                    state_n = DRAIN;
                    rd_n    = '0;
                end else begin
                    do_swap = cmp_z;
                    if (i == (limit - IW'(1))) begin
                        // Early exit when a whole pass (including this step) swapped nothing.
                        if (!(swapped || cmp_z) || (limit == IW'(1))) begin
                            state_n = DRAIN;
                            rd_n    = '0;
                        end else begin
                            limit_n   = limit - IW'(1);
                            i_n       = '0;
                            swapped_n = 1'b0;
                        end
                    end else begin
                        i_n       = ip1;
                        swapped_n = swapped | cmp_z;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (rd == IW'(count - CW'(1))) begin
                        state_n = LOAD;
                        count_n = '0;
                        rd_n    = '0;
                    end else begin
                        rd_n = rd + IW'(1);
                    end
                end
            end
            default: state_n = LOAD;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= LOAD;
        else          state <= state_n;
    end

    // Index, count and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            i        <= '0;
            limit    <= '0;
            rd       <= '0;
            swapped  <= 1'b0;
            sorted_q <= 1'b0;
        end else begin
            count    <= count_n;
            i        <= i_n;
            limit    <= limit_n;
            rd       <= rd_n;
            swapped  <= swapped_n;
            sorted_q <= (state == SORT) && (state_n == DRAIN);
        end
    end

    // Word storage: load writes and in-place swaps; contents need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[IW'(count)] <= in_data;
        end else if (do_swap) begin
            mem[i]   <= mem[ip1];
            mem[ip1] <= mem[i];
        end
    end
endmodule

// File: tb/tb_sort_engine.sv
// Self-checking bench for sort_engine: table-driven batches plus hand-written
// sequences for full buffer, backpressure, empty start and asynchronous reset.
module tb_sort_engine;
    localparam int N     = 8;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset_n, in_valid, start, out_ready;
    logic [N:0] in_data;
    logic       in_ready, busy, sorted, out_valid;
    logic [N:0] out_data;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [7:0]          n;
        logic [7:0]          busy_cyc;
        logic                merge;
        logic [0:7][8:0]     din;
        logic [0:7][8:0]     dout;
    } vec_t;

    vec_t vecs [5];

    sort_engine #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .start(start), .busy(busy), .sorted(sorted),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Load v.n words back to back; start either with the last word or one cycle later.
    task automatic load_words(input vec_t v);
        for (int k = 0; k < int'(v.n); k++) begin
            in_valid = 1'b1;
            in_data  = v.din[k];
            check("in_ready_load", in_ready, 1);
            if (v.merge && (k == int'(v.n) - 1)) start = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (!v.merge) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    // Count busy cycles (bounded) and check the DRAIN entry cycle.
    task automatic wait_sort(input int exp_cyc);
        int cyc = 0;
        while (busy && cyc < 200) begin
            check("in_ready_sort", in_ready, 0);
            cyc++;
            @(negedge clk);
        end
        check("busy_cycles", cyc, exp_cyc);
        check("sorted_pulse", sorted, 1);
        check("out_valid_first", out_valid, 1);
    endtask

    // Drain with out_ready held high, one word per cycle.
    task automatic drain(input vec_t v);
        int extra = 0;
        out_ready = 1'b1;
        for (int k = 0; k < int'(v.n); k++) begin
            check("out_valid_drain", out_valid, 1);
            check("out_data", out_data, v.dout[k]);
            if (k > 0) extra += int'(sorted);
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("sorted_single", extra, 0);
        check("in_ready_after", in_ready, 1);
        check("out_valid_after", out_valid, 0);
        check("out_data_idle", out_data, 0);
    endtask

    task automatic run_vec(input vec_t v);
        load_words(v);
        wait_sort(int'(v.busy_cyc));
        drain(v);
    endtask

    task automatic pulse_reset;
        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_sorted", sorted, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        vec_t vfull, vbp;
        bit   pat [8] = '{1, 0, 0, 1, 0, 1, 1, 0};
        int   idx, cyc;
        bit   stalled;
        logic [N:0] held;

        vecs[0] = '{n: 8, busy_cyc: 28, merge: 0,
                    din:  {9'd8, 9'd7, 9'd6, 9'd5, 9'd4, 9'd3, 9'd2, 9'd1},
                    dout: {9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6, 9'd7, 9'd8}};
        vecs[1] = '{n: 6, busy_cyc: 14, merge: 0,
                    din:  {9'd3, 9'd3, 9'd9, 9'd0, 9'd511, 9'd9, 9'd0, 9'd0},
                    dout: {9'd0, 9'd3, 9'd3, 9'd9, 9'd9, 9'd511, 9'd0, 9'd0}};
        vecs[2] = '{n: 1, busy_cyc: 1, merge: 0,
                    din:  {9'd42, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0},
                    dout: {9'd42, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0}};
        vecs[3] = '{n: 5, busy_cyc: 4, merge: 0,
                    din:  {9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd0, 9'd0, 9'd0},
                    dout: {9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd0, 9'd0, 9'd0}};
        vecs[4] = '{n: 4, busy_cyc: 6, merge: 1,
                    din:  {9'd7, 9'd1, 9'd4, 9'd2, 9'd0, 9'd0, 9'd0, 9'd0},
                    dout: {9'd1, 9'd2, 9'd4, 9'd7, 9'd0, 9'd0, 9'd0, 9'd0}};
        vfull = '{n: 8, busy_cyc: 28, merge: 0,
                  din:  {9'd80, 9'd70, 9'd60, 9'd50, 9'd40, 9'd30, 9'd20, 9'd10},
                  dout: {9'd10, 9'd20, 9'd30, 9'd40, 9'd50, 9'd60, 9'd70, 9'd80}};
        vbp   = '{n: 3, busy_cyc: 3, merge: 0,
                  din:  {9'd5, 9'd1, 9'd3, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0},
                  dout: {9'd1, 9'd3, 9'd5, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0}};

        // Asynchronous reset before any clock edge.
        reset_n = 1'b1; in_valid = 1'b0; in_data = '0; start = 1'b0; out_ready = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_sorted", sorted, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Start with nothing loaded is ignored.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("empty_start_busy", busy, 0);
        check("empty_start_in_ready", in_ready, 1);
        @(negedge clk);
        check("empty_start_busy2", busy, 0);
        check("empty_start_out_valid", out_valid, 0);

        // Table-driven batches, back to back.
        for (int v = 0; v < 5; v++) run_vec(vecs[v]);

        // Full buffer: 9th offered word must be refused and never appear.
        for (int k = 0; k < 9; k++) begin
            in_valid = 1'b1;
            in_data  = (k < 8) ? vfull.din[k] : 9'd5;
            check("full_in_ready", in_ready, (k < 8) ? 1 : 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_sort(28);
        drain(vfull);

        // Backpressure with out_ready pattern 1,0,0,1,0,1,1,0.
        load_words(vbp);
        wait_sort(3);
        idx = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (idx < 3 && cyc < 40) begin
            if (stalled) check("bp_stable", out_data, held);
            check("bp_out_valid", out_valid, 1);
            out_ready = pat[cyc % 8];
            if (out_ready) begin
                check("bp_data", out_data, vbp.dout[idx]);
                idx++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = out_data;
            end
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("bp_count", idx, 3);
        check("bp_in_ready", in_ready, 1);
        check("bp_out_valid_end", out_valid, 0);

        // Reset during SORT.
        load_words(vecs[0]);
        for (int k = 0; k < 5; k++) begin
            check("pre_reset_busy", busy, 1);
            @(negedge clk);
        end
        pulse_reset();

        // Reset during DRAIN, after two words have gone out.
        load_words(vecs[3]);
        wait_sort(4);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("pre_reset_out_valid", out_valid, 1);
        pulse_reset();

        // Fresh batches sort correctly after reset.
        run_vec(vecs[1]);
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
